regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (w_ena/w_addr/w_data) between two writeback sources.
- Port 0 is the in-order pipeline writeback. Port 1 is a long-latency unit (e.g., a multi-cycle divider or load return).
- Port 1 requests are buffered in a small FIFO and drained whenever port 0 is idle.
- Publishes a busy mask of registers with writes still pending in the FIFO, so issue logic can stall on RAW/WAW hazards.

Parameters:
- P1_DEPTH, 2: port-1 FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO may be blocked before port 0 is throttled; only used with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- p0_valid  in  1  pipeline writeback request
- p0_ready  out  1  port 0 accepted this cycle
- p0_addr  in  5  destination register
- p0_data  in  32  write data
- p1_valid  in  1  long-latency writeback request
- p1_ready  out  1  FIFO can accept
- p1_addr  in  5  destination register
- p1_data  in  32  write data
- w_ena  out  1  register file write enable (registered)
- w_addr  out  5  register file write address (registered)
- w_data  out  32  register file write data (registered)
- busy_mask  out  32  bit i set if a FIFO entry targets register i (i≠0)
- fifo_count  out  clog2(P1_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, rst=1 at a clk edge: FIFO empty; w_ena=0, w_addr=0, w_data=0; busy_mask=0; fifo_count=0; starvation counter=0.
- While rst=1, p0_ready=0 and p1_ready=0. Reset mid-operation discards all buffered entries with no write.
- Handshake: a transfer occurs on a cycle where valid && ready. Payload must stay stable while valid && !ready.
- p0_ready is 1 except when the starvation throttle is active (optional feature).
- p1_ready = !full. A push is refused when the FIFO is full, even if a pop happens the same cycle.
- Grant, evaluated each cycle:
  - If p0 transfers, the write-port slot is p0.
  - Else if the FIFO is non-empty, the slot is the FIFO head, which pops.
  - Else no write.
- Latency: the slot is registered onto w_ena/w_addr/w_data at the next clk edge, so a write appears exactly 1 cycle after acceptance. w_ena=0 on idle cycles; w_addr/w_data hold their last values.
- r0 writes: a slot with addr=0 is consumed (handshake completes, FIFO pops) but w_ena stays 0.
- FIFO:
  - Circular buffer with rd/wr pointers that wrap modulo P1_DEPTH.
  - Push and pop in the same cycle (not full) leaves fifo_count unchanged.
  - A push into an empty FIFO is not eligible to drain until the following cycle (no flow-through).
- busy_mask:
  - Combinational OR of one-hot(addr) over all valid FIFO entries; bit 0 is forced to 0.
  - Updates the cycle after a push or pop.
  - Issue logic must not send a p0 write to a register whose busy bit is set. The arbiter does not reorder same-address writes.
- Ordering: writes from the same port retire in acceptance order. Port 1 entries retire in FIFO order.

Optional Feature:
- Macro: REGFILE_WB_STARVE_GUARD_EN.
- Defined:
  - Counter increments each cycle the FIFO is non-empty and does not pop; it clears on any pop.
  - When counter == STARVE_LIMIT, p0_ready=0 for exactly that cycle, forcing the FIFO head to drain; the counter then clears.
- Undefined: no counter; p0_ready is constantly 1 outside reset; port 1 may starve indefinitely under continuous port-0 traffic.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_NUM=32.
  - A writeback-request typedef {addr, data}.
- Natural sub-module: wb_sync_fifo, a parameterised depth/width synchronous FIFO with count, full and empty flags, and per-entry valid/addr exposure for busy_mask.

Test Plan:
- Reset then idle: all outputs 0; p0_valid=1, addr=5, data=0xDEADBEEF → next cycle w_ena=1, w_addr=5, w_data=0xDEADBEEF.
- p1 push addr=7, data=0x11 with p0 idle → busy_mask=0x80 one cycle after accept; the following cycle w_ena=1, w_addr=7; busy_mask returns to 0 the cycle after the pop.
- Fill the FIFO (2 pushes) while p0 is valid every cycle (guard off) → p1_ready=0, fifo_count=2, FIFO never drains until p0_valid drops; it then drains in 2 consecutive cycles in push order.
- Same as above with REGFILE_WB_STARVE_GUARD_EN, STARVE_LIMIT=4 → p0_ready=0 on the 5th blocked cycle and the FIFO head writes the next cycle.
- p0 addr=0 and p1 addr=0 requests → both handshakes complete, w_ena stays 0, busy_mask stays 0.
- Assert rst with 2 FIFO entries pending → no further writes occur, fifo_count=0 and busy_mask=0 after the reset edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Contents: REG_ADDR_W/REG_DATA_W/REG_NUM, the wb_req_t writeback payload,
// and a helper that turns a register address into a one-hot mask.
package regfile_wb_arbiter_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;
   localparam int unsigned REG_NUM    = 32;

   // Writeback payload carried by both ports and stored in the port-1 FIFO
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_req_t;

   localparam int unsigned WB_REQ_W = $bits(wb_req_t);

   // One-hot register mask for a destination address
   function automatic logic [REG_NUM-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
      reg_onehot = REG_NUM'(1) << addr;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the writeback arbiter.
// Port 0 request (p0_valid/p0_ready/p0_addr/p0_data), port 1 request
// (p1_valid/p1_ready/p1_addr/p1_data), register-file write port
// (w_ena/w_addr/w_data) and hazard status (busy_mask/fifo_count).
// slave: the arbiter side; master: the pipeline/regfile side.
interface regfile_wb_arbiter_if
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned P1_DEPTH = 2
);

   localparam int unsigned CNT_W = $clog2(P1_DEPTH) + 1;

   logic                  p0_valid;
   logic                  p0_ready;
   logic [REG_ADDR_W-1:0] p0_addr;
   logic [REG_DATA_W-1:0] p0_data;

   logic                  p1_valid;
   logic                  p1_ready;
   logic [REG_ADDR_W-1:0] p1_addr;
   logic [REG_DATA_W-1:0] p1_data;

   logic                  w_ena;
   logic [REG_ADDR_W-1:0] w_addr;
   logic [REG_DATA_W-1:0] w_data;

   logic [REG_NUM-1:0]    busy_mask;
   logic [CNT_W-1:0]      fifo_count;

   modport slave (
      input  p0_valid, p0_addr, p0_data,
      input  p1_valid, p1_addr, p1_data,
      output p0_ready, p1_ready,
      output w_ena, w_addr, w_data,
      output busy_mask, fifo_count
   );

   modport master (
      output p0_valid, p0_addr, p0_data,
      output p1_valid, p1_addr, p1_data,
      input  p0_ready, p1_ready,
      input  w_ena, w_addr, w_data,
      input  busy_mask, fifo_count
   );

endinterface

// File: rtl/regfile_wb_arbiter_wb_sync_fifo.sv
// Synchronous circular-buffer FIFO for buffered writeback requests.
// Ports: clk, rst (sync, active-high); push/wr_data in; pop in, rd_data out
// (head entry); full/empty/count status; entry_valid/entries expose every
// slot so the parent can derive hazard information from pending entries.
// Pushes while full and pops while empty are ignored.
module regfile_wb_arbiter_wb_sync_fifo #(
   parameter  int unsigned DEPTH = 2,
   parameter  int unsigned W     = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [W-1:0]              wr_data,
   input  logic                      pop,
   output logic [W-1:0]              rd_data,
   output logic                      full,
   output logic                      empty,
   output logic [CNT_W-1:0]          count,
   output logic [DEPTH-1:0]          entry_valid,
   output logic [DEPTH-1:0][W-1:0]   entries
);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic                    do_push;
   logic                    do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];
   assign entries = mem;

   // Storage: no reset needed, validity is tracked separately
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         entry_valid <= '0;
      end else begin
         if (do_push) begin
            wr_ptr              <= wr_ptr + PTR_W'(1);
            entry_valid[wr_ptr] <= 1'b1;
         end
         if (do_pop) begin
            rd_ptr              <= rd_ptr + PTR_W'(1);
            entry_valid[rd_ptr] <= 1'b0;
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the in-order pipeline
// writeback (port 0, priority) and a long-latency unit (port 1, buffered in a
// FIFO and drained when port 0 is idle). Publishes busy_mask of registers with
// writes still pending in the FIFO.
// Ports: clk, rst (sync, active-high), bus (regfile_wb_arbiter_if.slave).
// Optional: define REGFILE_WB_STARVE_GUARD_EN to throttle port 0 for one cycle
// after the FIFO head has been blocked STARVE_LIMIT consecutive cycles.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned P1_DEPTH     = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_arbiter_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(P1_DEPTH) + 1;

   if (P1_DEPTH < 2 || (P1_DEPTH & (P1_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
      $error("regfile_wb_arbiter: P1_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
   end

   wb_req_t                          p1_req;
   wb_req_t                          head;
   wb_req_t                          slot;
   logic                             slot_valid;
   logic                             full;
   logic                             empty;
   logic                             p0_fire;
   logic                             push;
   logic                             pop;
   logic                             throttle;
   logic [CNT_W-1:0]                 count;
   logic [P1_DEPTH-1:0]              entry_valid;
   logic [P1_DEPTH-1:0][WB_REQ_W-1:0] entries;
   logic [REG_NUM-1:0]               busy;

   logic                             w_ena_q;
   logic [REG_ADDR_W-1:0]            w_addr_q;
   logic [REG_DATA_W-1:0]            w_data_q;

`ifdef REGFILE_WB_STARVE_GUARD_EN
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
   logic [STARVE_W-1:0] starve_cnt;

   // Counts consecutive cycles the FIFO head waited; a throttle cycle always pops
   always_ff @(posedge clk) begin
      if (rst || pop || empty) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end

   assign throttle = (starve_cnt == STARVE_W'(STARVE_LIMIT));
`else
   assign throttle = 1'b0;
`endif

   assign bus.p0_ready = !rst && !throttle;
   assign bus.p1_ready = !rst && !full;

   assign p0_fire = bus.p0_valid && bus.p0_ready;
   assign push    = bus.p1_valid && bus.p1_ready;
   // Empty is registered, so a freshly pushed entry cannot drain the same cycle
   assign pop     = !rst && !p0_fire && !empty;

   assign p1_req = '{addr: bus.p1_addr, data: bus.p1_data};

   regfile_wb_arbiter_wb_sync_fifo #(
      .DEPTH (P1_DEPTH),
      .W     (WB_REQ_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .wr_data     (p1_req),
      .pop         (pop),
      .rd_data     (head),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .entry_valid (entry_valid),
      .entries     (entries)
   );

   // Write-port grant: port 0 first, then the FIFO head
   always_comb begin
      slot_valid = 1'b0;
      slot       = '0;
      if (p0_fire) begin
         slot_valid = 1'b1;
         slot       = '{addr: bus.p0_addr, data: bus.p0_data};
      end else if (pop) begin
         slot_valid = 1'b1;
         slot       = head;
      end
   end

   // Registered write port; r0 slots are consumed without a write
   always_ff @(posedge clk) begin
      if (rst) begin
         w_ena_q  <= 1'b0;
         w_addr_q <= '0;
         w_data_q <= '0;
      end else begin
         w_ena_q <= slot_valid && (slot.addr != '0);
         if (slot_valid && (slot.addr != '0)) begin
            w_addr_q <= slot.addr;
            w_data_q <= slot.data;
         end
      end
   end

   // Pending-write hazard mask over all valid FIFO entries
   always_comb begin
      wb_req_t ent;
      busy = '0;
      ent  = '0;
      for (int unsigned i = 0; i < P1_DEPTH; i++) begin
         ent = entries[i];
         if (entry_valid[i]) begin
            busy = busy | reg_onehot(ent.addr);
         end
      end
      busy[0] = 1'b0;
   end

   assign bus.w_ena      = w_ena_q;
   assign bus.w_addr     = w_addr_q;
   assign bus.w_data     = w_data_q;
   assign bus.busy_mask  = busy;
   assign bus.fifo_count = count;

endmodule
